// File: rtl/fe_pkg.sv
// fe_pkg: shared types and constants for the streaming feature extractor.
package fe_pkg;
  typedef enum logic [1:0] {ACT_BYPASS, ACT_RELU, ACT_LEAKY} act_mode_e;
  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} fe_state_e;
  localparam int KERNEL    = 3;
  localparam int N_TAPS    = 9;
  localparam int FLUSH_CYC = 4;
endpackage

// File: rtl/fe_line_buffer.sv
// fe_line_buffer: two raster line buffers feeding a 3x3 sliding window, with
// window-valid flag and the conv column / row parity of the window produced.
module fe_line_buffer
  import fe_pkg::*;
#(
  parameter int IMG_W = 32,
  parameter int IMG_H = 32,
  parameter int PIX_W = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          clr_i,
  input  logic                          acc_i,
  input  logic [PIX_W-1:0]              pix_i,
  output logic [N_TAPS-1:0][PIX_W-1:0]  win_o,
  output logic                          win_valid_o,
  output logic [$clog2(IMG_W)-1:0]      cc_o,
  output logic                          row_odd_o,
  output logic                          last_o
);
  localparam int CB = $clog2(IMG_W);
  localparam int RB = $clog2(IMG_H);
  logic [CB-1:0]    col_q;
  logic [RB-1:0]    row_q;
  logic [PIX_W-1:0] lb0_q [IMG_W];
  logic [PIX_W-1:0] lb1_q [IMG_W];
  logic             last_col;
  assign last_col = col_q == CB'(IMG_W-1);
  assign last_o   = acc_i && last_col && row_q == RB'(IMG_H-1);
  // lb0 holds the previous row, lb1 the one before; the window's right column comes from them
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col_q       <= '0;
      row_q       <= '0;
      win_o       <= '0;
      win_valid_o <= 1'b0;
      cc_o        <= '0;
      row_odd_o   <= 1'b0;
      for (int c = 0; c < IMG_W; c++) begin
        lb0_q[c] <= '0;
        lb1_q[c] <= '0;
      end
    end else begin
      win_valid_o <= acc_i && row_q >= RB'(2) && col_q >= CB'(2);
      if (clr_i) begin
        col_q <= '0;
        row_q <= '0;
      end else if (acc_i) begin
        for (int i = 0; i < KERNEL; i++)
          for (int j = 0; j < KERNEL-1; j++)
            win_o[i*KERNEL+j] <= win_o[i*KERNEL+j+1];
        win_o[KERNEL-1]   <= lb1_q[col_q];
        win_o[2*KERNEL-1] <= lb0_q[col_q];
        win_o[N_TAPS-1]   <= pix_i;
        lb1_q[col_q]      <= lb0_q[col_q];
        lb0_q[col_q]      <= pix_i;
        col_q             <= last_col ? '0 : col_q + 1'b1;
        if (last_col) row_q <= last_o ? '0 : row_q + 1'b1;
        cc_o              <= col_q - CB'(2);
        row_odd_o         <= row_q[0];
      end
    end
  end
endmodule

// File: rtl/feature_extractor_param.sv
// feature_extractor_param: 3x3 conv -> activation -> optional 2x2 max pool stream.
// Define FE_LEAKY_RELU_EN to make act_mode 10 a leaky ReLU (otherwise it is ReLU).
module feature_extractor_param
  import fe_pkg::*;
#(
  parameter int IMG_W       = 32,
  parameter int IMG_H       = 32,
  parameter int PIX_W       = 8,
  parameter int WT_W        = 8,
  parameter int ACC_W       = 22,
  parameter int LEAKY_SHIFT = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start_signal,
  input  logic                    pixel_valid_in,
  input  logic [PIX_W-1:0]        pixel_in,
  input  logic                    wt_wr_en,
  input  logic [3:0]              wt_addr,
  input  logic [WT_W-1:0]         wt_data,
  input  logic [1:0]              act_mode,
  input  logic                    pool_en,
  output logic signed [ACC_W-1:0] final_result_out,
  output logic                    final_result_valid,
  output logic                    final_done_signal,
  output logic                    busy
);
  localparam int PW  = PIX_W + WT_W + 1;
  localparam int CB  = $clog2(IMG_W);
  localparam int NPW = (IMG_W - 2) / 2;
  localparam int PB  = $clog2(NPW + 1);
  localparam int FB  = $clog2(FLUSH_CYC);
`ifdef FE_LEAKY_RELU_EN
  localparam act_mode_e MODE10 = ACT_LEAKY;
`else
  localparam act_mode_e MODE10 = ACT_RELU;
`endif
  if (ACC_W < PIX_W + WT_W + 5) begin : g_acc_chk
    $error("ACC_W too narrow for a full-precision 3x3 sum");
  end
  if (LEAKY_SHIFT < 0 || LEAKY_SHIFT >= ACC_W) begin : g_shift_chk
    $error("LEAKY_SHIFT out of range");
  end
  fe_state_e               state_q;
  logic [FB-1:0]           fcnt_q;
  act_mode_e               mode_q;
  logic                    pool_q, done_q, busy_q;
  logic signed [WT_W-1:0]  w_q [N_TAPS];
  logic                    accept, clr, last, wv, ro;
  logic [N_TAPS-1:0][PIX_W-1:0] win;
  logic [CB-1:0]           cc, cc1_q, cc2_q, cc3_q;
  logic signed [PW-1:0]    prod_d [N_TAPS];
  logic signed [PW-1:0]    prod_q [N_TAPS];
  logic signed [ACC_W-1:0] sum_d, sum_q, act_d, a3_q, hmax_q, m_d, pool_d, res_q;
  logic signed [ACC_W-1:0] pbuf_q [2**PB];
  logic [PB-1:0]           idx;
  logic                    v1_q, v2_q, v3_q, ro1_q, ro2_q, ro3_q, out_v, valid_q;
  assign accept             = pixel_valid_in && state_q == RUN;
  assign clr                = start_signal && state_q == IDLE;
  assign final_result_out   = res_q;
  assign final_result_valid = valid_q;
  assign final_done_signal  = done_q;
  assign busy               = busy_q;
  fe_line_buffer #(.IMG_W(IMG_W), .IMG_H(IMG_H), .PIX_W(PIX_W)) u_lb (
    .clk(clk), .rst(rst), .clr_i(clr), .acc_i(accept), .pix_i(pixel_in),
    .win_o(win), .win_valid_o(wv), .cc_o(cc), .row_odd_o(ro), .last_o(last)
  );
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      fcnt_q  <= '0;
      mode_q  <= ACT_BYPASS;
      pool_q  <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (start_signal) begin
          state_q <= RUN;
          busy_q  <= 1'b1;
          pool_q  <= pool_en;
          mode_q  <= act_mode == 2'b00 ? ACT_BYPASS : act_mode == 2'b10 ? MODE10 : ACT_RELU;
        end
        RUN: if (last) begin
          state_q <= FLUSH;
          fcnt_q  <= '0;
        end
        FLUSH: begin
          fcnt_q <= fcnt_q + 1'b1;
          if (fcnt_q == FB'(FLUSH_CYC-1)) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
        end
      endcase
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < N_TAPS; k++) w_q[k] <= k == N_TAPS/2 ? WT_W'(1) : '0;
    end else if (wt_wr_en && state_q == IDLE && wt_addr < 4'(N_TAPS)) begin
      w_q[wt_addr] <= wt_data;
    end
  end
  always_comb begin
    sum_d = '0;
    for (int k = 0; k < N_TAPS; k++) begin
      prod_d[k] = $signed({1'b0, win[k]}) * w_q[k];
      sum_d     = sum_d + {{(ACC_W-PW){prod_q[k][PW-1]}}, prod_q[k]};
    end
`ifdef FE_LEAKY_RELU_EN
    act_d = (mode_q == ACT_BYPASS || !sum_q[ACC_W-1]) ? sum_q :
            mode_q == ACT_LEAKY ? sum_q >>> LEAKY_SHIFT : '0;
`else
    act_d = (mode_q == ACT_BYPASS || !sum_q[ACC_W-1]) ? sum_q : '0;
`endif
    idx    = PB'(cc3_q >> 1);
    m_d    = a3_q > hmax_q ? a3_q : hmax_q;
    pool_d = pbuf_q[idx] > m_d ? pbuf_q[idx] : m_d;
    out_v  = pool_q ? v3_q && cc3_q[0] && ro3_q : v2_q;
  end
  // even conv columns seed the horizontal max; odd columns close a pair, even rows park it, odd rows emit
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < N_TAPS; k++) prod_q[k] <= '0;
      for (int k = 0; k < 2**PB; k++) pbuf_q[k] <= '0;
      {v1_q, v2_q, v3_q, ro1_q, ro2_q, ro3_q, valid_q} <= '0;
      {cc1_q, cc2_q, cc3_q} <= '0;
      {sum_q, a3_q, hmax_q, res_q} <= '0;
    end else begin
      prod_q  <= prod_d;
      v1_q    <= wv;
      cc1_q   <= cc;
      ro1_q   <= ro;
      sum_q   <= sum_d;
      v2_q    <= v1_q;
      cc2_q   <= cc1_q;
      ro2_q   <= ro1_q;
      a3_q    <= act_d;
      v3_q    <= v2_q && pool_q;
      cc3_q   <= cc2_q;
      ro3_q   <= ro2_q;
      if (v3_q && !cc3_q[0]) hmax_q <= a3_q;
      if (v3_q && cc3_q[0] && !ro3_q) pbuf_q[idx] <= m_d;
      valid_q <= out_v;
      if (out_v) res_q <= pool_q ? pool_d : act_d;
    end
  end
endmodule

// File: tb/tb_feature_extractor_param.sv
// tb_feature_extractor_param: directed + randomized frames against a plain-arithmetic reference model.
module tb_feature_extractor_param;
  localparam int W = 32, H = 32, PW = 8, WW = 8, AW = 22, LS = 3;
`ifdef FE_LEAKY_RELU_EN
  localparam bit LEAKY = 1'b1;
`else
  localparam bit LEAKY = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1, start_signal = 1'b0, pixel_valid_in = 1'b0, wt_wr_en = 1'b0, pool_en = 1'b0;
  logic [PW-1:0] pixel_in = '0;
  logic [3:0] wt_addr = '0;
  logic [WW-1:0] wt_data = '0;
  logic [1:0] act_mode = '0;
  logic signed [AW-1:0] final_result_out;
  logic final_result_valid, final_done_signal, busy;
  int vec = 0, miss = 0, edge_n = 0, done_cnt = 0;
  int img [H][W];
  int wts [9];
  int acc_e [W*H];
  int outq[$], tq[$], exp_q[$], save1[$], save2[$];

  feature_extractor_param dut (
    .clk(clk), .rst(rst), .start_signal(start_signal), .pixel_valid_in(pixel_valid_in),
    .pixel_in(pixel_in), .wt_wr_en(wt_wr_en), .wt_addr(wt_addr), .wt_data(wt_data),
    .act_mode(act_mode), .pool_en(pool_en), .final_result_out(final_result_out),
    .final_result_valid(final_result_valid), .final_done_signal(final_done_signal), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    edge_n++;
    #1;
    if (final_result_valid) begin
      outq.push_back(int'(final_result_out));
      tq.push_back(edge_n);
    end
    if (final_done_signal) done_cnt++;
  end

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    vec++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int act(input int x, input logic [1:0] md);
    if (md == 2'b00) return x;
    if (md == 2'b10 && LEAKY) return x < 0 ? x >>> LS : x;
    return x < 0 ? 0 : x;
  endfunction

  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

  function automatic void model(input bit pl, input logic [1:0] md);
    int cv [H-2][W-2];
    int s;
    exp_q.delete();
    for (int r = 0; r < H-2; r++)
      for (int c = 0; c < W-2; c++) begin
        s = 0;
        for (int i = 0; i < 3; i++)
          for (int j = 0; j < 3; j++) s += wts[i*3+j] * img[r+i][c+j];
        cv[r][c] = act(s, md);
        if (!pl) exp_q.push_back(cv[r][c]);
      end
    if (pl)
      for (int i = 0; i < (H-2)/2; i++)
        for (int j = 0; j < (W-2)/2; j++)
          exp_q.push_back(max4(cv[2*i][2*j], cv[2*i][2*j+1], cv[2*i+1][2*j], cv[2*i+1][2*j+1]));
  endfunction

  task automatic cmp_frame(input string tag);
    chk({tag, "_count"}, outq.size(), exp_q.size());
    for (int i = 0; i < outq.size() && i < exp_q.size(); i++)
      chk($sformatf("%s[%0d]", tag, i), outq[i], exp_q[i]);
  endtask

  task automatic set_img(input int kind);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        img[r][c] = kind == 0 ? r + c : kind == 1 ? 10 : int'($urandom_range(0, 255));
  endtask

  task automatic wr_wt(input int a, input int d);
    wt_wr_en = 1'b1;
    wt_addr  = 4'(a);
    wt_data  = WW'(d);
    @(posedge clk); #2;
    wt_wr_en = 1'b0;
    if (a < 9) wts[a] = d;
  endtask

  task automatic run_frame(input bit pl, input logic [1:0] md, input bit gap, input int abort_at, input bit tamper);
    int d0, n, k;
    outq.delete();
    tq.delete();
    d0 = done_cnt;
    start_signal = 1'b1;
    act_mode = md;
    pool_en = pl;
    @(posedge clk); #2;
    start_signal = 1'b0;
    act_mode = ~md;
    pool_en = ~pl;
    for (int p = 0; p < W*H; p++) begin
      n = gap ? (p % 2) + ($urandom_range(0, 3) == 0 ? int'($urandom_range(1, 5)) : 0) : 0;
      repeat (n) begin
        pixel_valid_in = 1'b0;
        pixel_in = PW'($urandom);
        @(posedge clk); #2;
      end
      if (p == abort_at) begin
        rst = 1'b0;
        #1;
        chk("abort_result", final_result_out, 0);
        chk("abort_valid", final_result_valid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done_sig", final_done_signal, 0);
        repeat (3) @(posedge clk);
        #2;
        chk("abort_no_done", done_cnt, d0);
        rst = 1'b1;
        for (int t = 0; t < 9; t++) wts[t] = t == 4 ? 1 : 0;
        @(posedge clk); #2;
        return;
      end
      pixel_valid_in = 1'b1;
      pixel_in = PW'(img[p/W][p%W]);
      if (tamper && p == 100) begin
        wt_wr_en = 1'b1;
        wt_addr = 4'd4;
        wt_data = WW'(5);
        start_signal = 1'b1;
      end
      if (tamper && p == W*H-1) start_signal = 1'b1;
      @(posedge clk); #2;
      acc_e[p] = edge_n;
      pixel_valid_in = 1'b0;
      wt_wr_en = 1'b0;
      start_signal = 1'b0;
    end
    k = 0;
    while (done_cnt == d0 && k < 40) begin
      @(posedge clk); #2;
      k++;
    end
    chk("done_pulse", done_cnt, d0 + 1);
    chk("busy_at_done", busy, 0);
    repeat (3) @(posedge clk);
    #2;
    chk("done_once", done_cnt, d0 + 1);
    chk("busy_idle", busy, 0);
  endtask

  initial begin
    for (int t = 0; t < 9; t++) wts[t] = t == 4 ? 1 : 0;
    #2 rst = 1'b0;
    #10;
    chk("rst_result", final_result_out, 0);
    chk("rst_valid", final_result_valid, 0);
    chk("rst_done", final_done_signal, 0);
    chk("rst_busy", busy, 0);
    @(posedge clk); #2;
    rst = 1'b1;
    @(posedge clk); #2;
    // identity weights, bypass, no pool
    set_img(0);
    run_frame(1'b0, 2'b00, 1'b0, -1, 1'b0);
    model(1'b0, 2'b00);
    cmp_frame("t1");
    save1 = outq;
    chk("t1_first", outq.size() > 0 ? outq[0] : -1, 2);
    chk("t1_latency", tq.size() > 0 ? tq[0] : -1, acc_e[2*W+2] + 3);
    // pooled
    run_frame(1'b1, 2'b00, 1'b0, -1, 1'b0);
    model(1'b1, 2'b00);
    cmp_frame("t2");
    save2 = outq;
    chk("t2_first", outq.size() > 0 ? outq[0] : -1, 4);
    chk("t2_latency", tq.size() > 0 ? tq[0] : -1, acc_e[3*W+3] + 4);
    // all -1 weights on a constant image, each activation
    for (int t = 0; t < 9; t++) wr_wt(t, -1);
    set_img(1);
    for (int m = 0; m < 3; m++) begin
      run_frame(1'b0, 2'(m), 1'b0, -1, 1'b0);
      model(1'b0, 2'(m));
      cmp_frame($sformatf("t3_mode%0d", m));
      chk($sformatf("t3_first_mode%0d", m), outq.size() > 0 ? outq[0] : -1,
          m == 0 ? -90 : m == 1 ? 0 : LEAKY ? -12 : 0);
    end
    // pooled frame with valid gaps must match the gap-free sequence
    for (int t = 0; t < 9; t++) wr_wt(t, t == 4 ? 1 : 0);
    set_img(0);
    run_frame(1'b1, 2'b00, 1'b1, -1, 1'b0);
    exp_q = save2;
    cmp_frame("t4");
    // reset mid-frame, then a clean frame
    run_frame(1'b0, 2'b00, 1'b0, 500, 1'b0);
    run_frame(1'b0, 2'b00, 1'b0, -1, 1'b0);
    exp_q = save1;
    cmp_frame("t5");
    // weight write and start during RUN are ignored; the same write in IDLE takes effect
    run_frame(1'b0, 2'b00, 1'b0, -1, 1'b1);
    exp_q = save1;
    cmp_frame("t6_ignored");
    wr_wt(4, 5);
    run_frame(1'b0, 2'b00, 1'b0, -1, 1'b0);
    model(1'b0, 2'b00);
    cmp_frame("t6_x5");
    chk("t6_first", outq.size() > 0 ? outq[0] : -1, 10);
    // randomized frames
    for (int f = 0; f < 3; f++) begin
      bit pl;
      logic [1:0] md;
      for (int t = 0; t < 9; t++) wr_wt(t, int'($urandom_range(0, 255)) - 128);
      wr_wt(9 + f, 7);
      set_img(2);
      pl = 1'($urandom_range(0, 1));
      md = 2'($urandom_range(0, 3));
      run_frame(pl, md, 1'b1, -1, 1'b0);
      model(pl, md);
      cmp_frame($sformatf("rnd%0d", f));
    end
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end
endmodule
